// File: rtl/score_tracker.sv
// score_tracker: per-player Gomoku match score keeper.
// Counts rising edges of win_p1/win_p2 as games won, keeps two-digit packed-BCD
// scores for the 7-segment driver, and latches the match result when a player
// reaches MATCH_WINS. Optional undo support is compiled in with SCORE_UNDO_EN.
//
// Handshake: there is no valid/ready pairing. win_p1, win_p2 (and undo) are
// levels whose rising edge is one event. new_match is a level that is honoured
// on every edge it is high. All outputs are registered or decoded from registers.
module score_tracker #(
  parameter logic [7:0] MATCH_WINS = 8'h05
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       win_p1,
  input  logic       win_p2,
  input  logic       new_match,
`ifdef SCORE_UNDO_EN
  input  logic       undo,
`endif
  output logic [7:0] num_p1,
  output logic [7:0] num_p2,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       draw
);

  typedef enum logic {S_PLAY = 1'b0, S_OVER = 1'b1} state_t;

  state_t     state, state_n;
  logic [7:0] p1_n, p2_n;
  logic [7:0] inc_p1, inc_p2;
  logic [1:0] winner_n;
  logic       draw_n;
  logic       win_p1_q, win_p2_q;
  logic       ev_p1, ev_p2;

  // BCD +1, saturating at 99 so a binary value never appears
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99)          bcd_inc = v;
    else if (v[3:0] == 4'h9) bcd_inc = {v[7:4] + 4'h1, 4'h0};
    else                     bcd_inc = {v[7:4], v[3:0] + 4'h1};
  endfunction

`ifdef SCORE_UNDO_EN
  logic       undo_q, ev_undo, undo_ok;
  logic [1:0] last_scorer, last_n;

  // BCD -1, floored at 00, borrowing from tens
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)          bcd_dec = v;
    else if (v[3:0] == 4'h0) bcd_dec = {v[7:4] - 4'h1, 4'h9};
    else                     bcd_dec = {v[7:4], v[3:0] - 4'h1};
  endfunction

  assign ev_undo = undo & ~undo_q;
  // win events take priority, so a coincident undo is simply dropped
  assign undo_ok = ev_undo & (last_scorer != 2'b00) & ~ev_p1 & ~ev_p2;
`endif

  assign ev_p1      = win_p1 & ~win_p1_q;
  assign ev_p2      = win_p2 & ~win_p2_q;
  assign inc_p1     = bcd_inc(num_p1);
  assign inc_p2     = bcd_inc(num_p2);
  assign match_over = (state == S_OVER);

  // Edge-detect history; resets high so a level already high at release is not a win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p1_q <= 1'b1;
      win_p2_q <= 1'b1;
`ifdef SCORE_UNDO_EN
      undo_q   <= 1'b1;
`endif
    end else begin
      win_p1_q <= win_p1;
      win_p2_q <= win_p2;
`ifdef SCORE_UNDO_EN
      undo_q   <= undo;
`endif
    end
  end

  // State, score and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_PLAY;
      num_p1       <= 8'h00;
      num_p2       <= 8'h00;
      match_winner <= 2'b00;
      draw         <= 1'b0;
`ifdef SCORE_UNDO_EN
      last_scorer  <= 2'b00;
`endif
    end else begin
      state        <= state_n;
      num_p1       <= p1_n;
      num_p2       <= p2_n;
      match_winner <= winner_n;
      draw         <= draw_n;
`ifdef SCORE_UNDO_EN
      last_scorer  <= last_n;
`endif
    end
  end

  // Next-state and next-score decode; new_match always wins
  always_comb begin
    state_n  = state;
    p1_n     = num_p1;
    p2_n     = num_p2;
    winner_n = match_winner;
    draw_n   = 1'b0;
`ifdef SCORE_UNDO_EN
    last_n   = last_scorer;
`endif
    if (new_match) begin
      state_n  = S_PLAY;
      p1_n     = 8'h00;
      p2_n     = 8'h00;
      winner_n = 2'b00;
`ifdef SCORE_UNDO_EN
      last_n   = 2'b00;
`endif
    end else begin
      case (state)
        S_PLAY: begin
          if (ev_p1 && ev_p2) begin
            draw_n = 1'b1;
`ifdef SCORE_UNDO_EN
            last_n = 2'b00;
`endif
          end else if (ev_p1) begin
            p1_n = inc_p1;
`ifdef SCORE_UNDO_EN
            last_n = 2'b01;
`endif
            if (inc_p1 == MATCH_WINS) begin
              state_n  = S_OVER;
              winner_n = 2'b01;
            end
          end else if (ev_p2) begin
            p2_n = inc_p2;
`ifdef SCORE_UNDO_EN
            last_n = 2'b10;
`endif
            if (inc_p2 == MATCH_WINS) begin
              state_n  = S_OVER;
              winner_n = 2'b10;
            end
          end
        end
        default: begin
          // OVER: result frozen, wins and draws ignored
        end
      endcase
`ifdef SCORE_UNDO_EN
      // Undo reverts the last increment and reopens a finished match
      if (undo_ok) begin
        if (last_scorer == 2'b01) p1_n = bcd_dec(num_p1);
        else                      p2_n = bcd_dec(num_p2);
        last_n   = 2'b00;
        state_n  = S_PLAY;
        winner_n = 2'b00;
      end
`endif
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: three instances (targets 05, 12, 99) share one
// stimulus stream and are compared every cycle against a decimal-integer
// model of the match rules. Undo stimulus is compiled with SCORE_UNDO_EN.
module tb_score_tracker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic win_p1 = 1'b1;
  logic win_p2 = 1'b0;
  logic new_match = 1'b0;
  logic undo = 1'b0;

  logic [7:0] num_p1_o [3];
  logic [7:0] num_p2_o [3];
  logic       over_o   [3];
  logic [1:0] winner_o [3];
  logic       draw_o   [3];

  int n_checks = 0;
  int n_errors = 0;

  // expected word: {num_p1, num_p2, match_over, match_winner, draw}
  logic [19:0] exp_q[$];

  typedef struct {
    int s1;
    int s2;
    int last;
    int winner;
    bit over;
    bit draw;
  } mdl_t;

  mdl_t m [3];
  int   tgt [3] = '{5, 12, 99};
  bit   h1, h2, hu;

  // clock
  always #5 clk = ~clk;

  score_tracker #(.MATCH_WINS(8'h05)) u5 (
    .clk(clk), .rst_n(rst_n), .win_p1(win_p1), .win_p2(win_p2), .new_match(new_match),
`ifdef SCORE_UNDO_EN
    .undo(undo),
`endif
    .num_p1(num_p1_o[0]), .num_p2(num_p2_o[0]), .match_over(over_o[0]),
    .match_winner(winner_o[0]), .draw(draw_o[0]));

  score_tracker #(.MATCH_WINS(8'h12)) u12 (
    .clk(clk), .rst_n(rst_n), .win_p1(win_p1), .win_p2(win_p2), .new_match(new_match),
`ifdef SCORE_UNDO_EN
    .undo(undo),
`endif
    .num_p1(num_p1_o[1]), .num_p2(num_p2_o[1]), .match_over(over_o[1]),
    .match_winner(winner_o[1]), .draw(draw_o[1]));

  score_tracker #(.MATCH_WINS(8'h99)) u99 (
    .clk(clk), .rst_n(rst_n), .win_p1(win_p1), .win_p2(win_p2), .new_match(new_match),
`ifdef SCORE_UNDO_EN
    .undo(undo),
`endif
    .num_p1(num_p1_o[2]), .num_p2(num_p2_o[2]), .match_over(over_o[2]),
    .match_winner(winner_o[2]), .draw(draw_o[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    to_bcd = 8'((s / 10) * 16 + (s % 10));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
    h1 = 1'b1; h2 = 1'b1; hu = 1'b1;
  endfunction

  function automatic void model_undo(input int i);
    if (m[i].last == 1 && m[i].s1 > 0) m[i].s1--;
    if (m[i].last == 2 && m[i].s2 > 0) m[i].s2--;
    m[i].last = 0;
    m[i].over = 1'b0;
    m[i].winner = 0;
  endfunction

  // One clock edge of match rules for every instance
  function automatic void model_step(input bit w1, input bit w2, input bit nm, input bit u);
    bit e1, e2, eu;
    e1 = w1 && !h1;
    e2 = w2 && !h2;
`ifdef SCORE_UNDO_EN
    eu = u && !hu;
`else
    eu = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      m[i].draw = 1'b0;
      if (nm) begin
        m[i] = '{0, 0, 0, 0, 1'b0, 1'b0};
      end else if (!m[i].over) begin
        if (e1 && e2) begin
          m[i].draw = 1'b1;
          m[i].last = 0;
        end else if (e1) begin
          if (m[i].s1 < 99) m[i].s1++;
          m[i].last = 1;
          if (m[i].s1 == tgt[i]) begin m[i].over = 1'b1; m[i].winner = 1; end
        end else if (e2) begin
          if (m[i].s2 < 99) m[i].s2++;
          m[i].last = 2;
          if (m[i].s2 == tgt[i]) begin m[i].over = 1'b1; m[i].winner = 2; end
        end else if (eu && m[i].last != 0) begin
          model_undo(i);
        end
      end else if (eu && !e1 && !e2 && m[i].last != 0) begin
        model_undo(i);
      end
      exp_q.push_back({to_bcd(m[i].s1), to_bcd(m[i].s2), m[i].over, 2'(m[i].winner), m[i].draw});
    end
    h1 = w1; h2 = w2; hu = u;
  endfunction

  task automatic compare_all();
    logic [19:0] e;
    for (int i = 0; i < 3; i++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("d%0d.num_p1", i), 32'(num_p1_o[i]), 32'(e[19:12]));
        check($sformatf("d%0d.num_p2", i), 32'(num_p2_o[i]), 32'(e[11:4]));
        check($sformatf("d%0d.match_over", i), 32'(over_o[i]), 32'(e[3]));
        check($sformatf("d%0d.match_winner", i), 32'(winner_o[i]), 32'(e[2:1]));
        check($sformatf("d%0d.draw", i), 32'(draw_o[i]), 32'(e[0]));
      end
    end
  endtask

  // Driver: apply inputs after negedge, step model at posedge, compare at negedge
  task automatic cycle(input bit w1, input bit w2, input bit nm, input bit u);
    win_p1 = w1; win_p2 = w2; new_match = nm; undo = u;
    @(posedge clk);
    model_step(w1, w2, nm, u);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_p1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, ".num_p1"}, 32'(num_p1_o[i]), 32'h00);
      check({tag, ".num_p2"}, 32'(num_p2_o[i]), 32'h00);
      check({tag, ".match_over"}, 32'(over_o[i]), 32'h0);
      check({tag, ".match_winner"}, 32'(winner_o[i]), 32'h0);
      check({tag, ".draw"}, 32'(draw_o[i]), 32'h0);
    end
  endtask

  initial begin
    // reset with win_p1 already high
    model_reset();
    #1;
    check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("held_high.num_p1", 32'(num_p1_o[0]), 32'h03);
    check("held_high.num_p2", 32'(num_p2_o[0]), 32'h00);

    // P2 to 12: BCD carry and same-edge match end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 9)  check("carry.pre", 32'(num_p2_o[1]), 32'h09);
      if (k == 10) check("carry.post", 32'(num_p2_o[1]), 32'h10);
      if (k == 11) check("target.not_yet", 32'(over_o[1]), 32'h0);
      if (k == 12) begin
        check("target.over", 32'(over_o[1]), 32'h1);
        check("target.winner", 32'(winner_o[1]), 32'h2);
        check("target.score", 32'(num_p2_o[1]), 32'h12);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // wins ignored while OVER
    for (int k = 0; k < 5; k++) pulse_p1();
    check("over_frozen.num_p1", 32'(num_p1_o[1]), 32'h00);
    check("over_frozen.num_p2", 32'(num_p2_o[1]), 32'h12);
    check("over_frozen.draw", 32'(draw_o[1]), 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("restart.over", 32'(over_o[1]), 32'h0);
    check("restart.num_p2", 32'(num_p2_o[1]), 32'h00);

    // simultaneous wins give a one-cycle draw
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("draw.pulse", 32'(draw_o[2]), 32'h1);
    check("draw.num_p1", 32'(num_p1_o[2]), 32'h00);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("draw.one_cycle", 32'(draw_o[2]), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    pulse_p1();
    check("pre_clear.num_p1", 32'(num_p1_o[2]), 32'h01);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("clear_beats_win", 32'(num_p1_o[2]), 32'h00);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // 100 P1 wins against the 99 target
    for (int k = 0; k < 100; k++) pulse_p1();
    check("sat.num_p1", 32'(num_p1_o[2]), 32'h99);
    check("sat.over", 32'(over_o[2]), 32'h1);
    check("sat.winner", 32'(winner_o[2]), 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    pulse_p1();
    pulse_p1();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset.num_p1", 32'(num_p1_o[0]), 32'h00);

`ifdef SCORE_UNDO_EN
    // undo reopens a finished match, is one level deep, and loses to wins
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) pulse_p1();
    check("undo.pre_over", 32'(over_o[0]), 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("undo.num_p1", 32'(num_p1_o[0]), 32'h04);
    check("undo.over", 32'(over_o[0]), 32'h0);
    check("undo.winner", 32'(winner_o[0]), 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("undo.second", 32'(num_p1_o[0]), 32'h04);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("undo.dropped.num_p2", 32'(num_p2_o[0]), 32'h01);
    check("undo.dropped.num_p1", 32'(num_p1_o[0]), 32'h04);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
